// File: rtl/pipeline_sequencer_pkg.sv
// Shared pipeline definitions: stall request encoding and sequencer state.
package pipeline_sequencer_pkg;

  typedef enum logic {
    NO_STALL       = 1'b0,
    STALL_PIPELINE = 1'b1
  } stall_pipeline_sig;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } seq_state_t;

  // Wide enough for MEM_TIMEOUT up to 255 and FLUSH_CYCLES up to 7.
  localparam int unsigned WaitCntWidth  = 8;
  localparam int unsigned FlushCntWidth = 3;

endpackage

// File: rtl/pipeline_sequencer_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: drives stage enables, bubbles and
// a saturating stall-cycle counter from load-use, branch, memory-wait and halt events.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  stall_pipeline_sig    load_use_stall_i,
  input  logic                 branch_taken_EXE_i,
  input  logic                 mem_req_MEM_i,
  input  logic                 mem_ready_i,
  input  logic                 halt_WB_i,
  input  logic                 resume_i,
  output logic                 pc_en_o,
  output logic                 fetch_en_o,
  output logic                 decode_en_o,
  output logic                 exe_en_o,
  output logic                 mem_en_o,
  output logic                 wb_en_o,
  output logic                 flush_decode_o,
  output logic                 flush_exe_o,
  output seq_state_t           state_o,
  output logic                 mem_timeout_o,
  output logic [CNT_WIDTH-1:0] stall_count_o
);

  localparam logic [FlushCntWidth-1:0] FlushLoad = FlushCntWidth'(FLUSH_CYCLES - 1);
  localparam logic [WaitCntWidth-1:0]  WaitLast  = WaitCntWidth'(MEM_TIMEOUT - 1);

  seq_state_t               state_q, state_d;
  logic [WaitCntWidth-1:0]  wait_cnt_q, wait_cnt_d;
  logic [FlushCntWidth-1:0] flush_cnt_q, flush_cnt_d;
  logic                     timeout_q, timeout_d;

  // {pc, fetch, decode, exe, mem, wb}
  logic [5:0] en;
  logic       flush_dec, flush_exe;
  logic       mem_stall;

  assign mem_stall = mem_req_MEM_i & ~mem_ready_i;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    en          = '1;
    flush_dec   = 1'b0;
    flush_exe   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          en         = '0;
          state_d    = MEM_WAIT;
          wait_cnt_d = WaitCntWidth'(1);
        end else begin
          if (branch_taken_EXE_i) begin
            flush_dec = 1'b1;
            flush_exe = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FlushLoad;
            end
          end else if (load_use_stall_i == STALL_PIPELINE) begin
            en[5:3]   = 3'b000;
            flush_exe = 1'b1;
          end
          if (halt_WB_i) begin
            state_d     = HALT;
            flush_cnt_d = '0;
          end
        end
      end

      MEM_WAIT: begin
        en = '0;
        if (mem_ready_i) begin
          en         = '1;
          wait_cnt_d = '0;
          // A wait that interrupted a flush resumes the remaining flush cycles.
          state_d    = (flush_cnt_q != '0) ? FLUSH : RUN;
        end else if (wait_cnt_q >= WaitLast) begin
          timeout_d   = 1'b1;
          state_d     = HALT;
          wait_cnt_d  = '0;
          flush_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      FLUSH: begin
        if (mem_stall) begin
          en         = '0;
          state_d    = MEM_WAIT;
          wait_cnt_d = WaitCntWidth'(1);
        end else begin
          flush_dec = 1'b1;
          if (branch_taken_EXE_i) begin
            flush_exe   = 1'b1;
            flush_cnt_d = FlushLoad;
          end else if (flush_cnt_q <= FlushCntWidth'(1)) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
          if (halt_WB_i) begin
            state_d     = HALT;
            flush_cnt_d = '0;
          end
        end
      end

      HALT: begin
        en = '0;
        if (resume_i && !timeout_q) begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  sat_counter #(
    .Width(CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (1'b0),
    .inc_i   (~&en),
    .count_o (stall_count_o)
  );

  assign pc_en_o        = en[5];
  assign fetch_en_o     = en[4];
  assign decode_en_o    = en[3];
  assign exe_en_o       = en[2];
  assign mem_en_o       = en[1];
  assign wb_en_o        = en[0];
  assign flush_decode_o = flush_dec;
  assign flush_exe_o    = flush_exe;
  assign state_o        = state_q;
  assign mem_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a scoreboard queue of expected outputs.
module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  localparam logic [7:0] AllOn  = 8'b111111_00;
  localparam logic [7:0] AllOff = 8'b000000_00;
  localparam logic [7:0] LdUse  = 8'b000111_01;
  localparam logic [7:0] Br     = 8'b111111_11;
  localparam logic [7:0] Fl     = 8'b111111_10;

  // Input patterns {load_use, branch, mem_req, mem_ready, halt, resume}
  localparam logic [5:0] Idle  = 6'b000000;
  localparam logic [5:0] InLu  = 6'b100000;
  localparam logic [5:0] InBr  = 6'b010000;
  localparam logic [5:0] InBrLu = 6'b110000;
  localparam logic [5:0] InMw  = 6'b001000;
  localparam logic [5:0] InMwBr = 6'b011000;
  localparam logic [5:0] InMr  = 6'b001100;
  localparam logic [5:0] InHlt = 6'b000010;
  localparam logic [5:0] InRes = 6'b000001;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  stall_pipeline_sig load_use = NO_STALL;
  logic              br = 1'b0, mreq = 1'b0, mrdy = 1'b0, halt = 1'b0, res = 1'b0;

  logic        pc_en, fetch_en, decode_en, exe_en, mem_en, wb_en, flush_dec, flush_exe;
  seq_state_t  state;
  logic        timeout;
  logic [31:0] stall_count;

  logic        s_pc, s_fe, s_de, s_ex, s_me, s_wb, s_fd, s_fx, s_to;
  seq_state_t  s_state;
  logic [1:0]  s_count;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .CNT_WIDTH    (32)
  ) u_dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .load_use_stall_i   (load_use),
    .branch_taken_EXE_i (br),
    .mem_req_MEM_i      (mreq),
    .mem_ready_i        (mrdy),
    .halt_WB_i          (halt),
    .resume_i           (res),
    .pc_en_o            (pc_en),
    .fetch_en_o         (fetch_en),
    .decode_en_o        (decode_en),
    .exe_en_o           (exe_en),
    .mem_en_o           (mem_en),
    .wb_en_o            (wb_en),
    .flush_decode_o     (flush_dec),
    .flush_exe_o        (flush_exe),
    .state_o            (state),
    .mem_timeout_o      (timeout),
    .stall_count_o      (stall_count)
  );

  // Narrow counter instance to exercise saturation on the same stimulus.
  pipeline_sequencer #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .CNT_WIDTH    (2)
  ) u_dut_sat (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .load_use_stall_i   (load_use),
    .branch_taken_EXE_i (br),
    .mem_req_MEM_i      (mreq),
    .mem_ready_i        (mrdy),
    .halt_WB_i          (halt),
    .resume_i           (res),
    .pc_en_o            (s_pc),
    .fetch_en_o         (s_fe),
    .decode_en_o        (s_de),
    .exe_en_o           (s_ex),
    .mem_en_o           (s_me),
    .wb_en_o            (s_wb),
    .flush_decode_o     (s_fd),
    .flush_exe_o        (s_fx),
    .state_o            (s_state),
    .mem_timeout_o      (s_to),
    .stall_count_o      (s_count)
  );

  function automatic logic [7:0] ctl_obs();
    return {pc_en, fetch_en, decode_en, exe_en, mem_en, wb_en, flush_dec, flush_exe};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare mid-cycle.
  task automatic step(input string tag, input logic [5:0] in, input logic [7:0] ctl,
                      input seq_state_t st, input logic to);
    exp_t e;
    load_use = in[5] ? STALL_PIPELINE : NO_STALL;
    br   = in[4];
    mreq = in[3];
    mrdy = in[2];
    halt = in[1];
    res  = in[0];
    e.ctl = ctl;
    e.st  = st;
    e.to  = to;
    e.cnt = exp_cnt;
    sb.push_back(e);
    if (ctl[7:2] != 6'h3f) exp_cnt++;
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".ctl"}, 32'(ctl_obs()), 32'(e.ctl));
    chk({tag, ".state"}, 32'(state), 32'(e.st));
    chk({tag, ".timeout"}, 32'(timeout), 32'(e.to));
    chk({tag, ".count"}, stall_count, e.cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ctl", 32'(ctl_obs()), 32'(AllOn));
    chk("rst.state", 32'(state), 32'(RUN));
    chk("rst.count", stall_count, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step("idle", Idle, AllOn, RUN, 1'b0);

    step("lu0", InLu, LdUse, RUN, 1'b0);
    step("lu1", Idle, AllOn, RUN, 1'b0);

    step("brlu0", InBrLu, Br, RUN, 1'b0);
    step("brlu1", Idle, Fl, FLUSH, 1'b0);
    step("brlu2", Idle, AllOn, RUN, 1'b0);

    step("rebr0", InBr, Br, RUN, 1'b0);
    step("rebr1", InBr, Br, FLUSH, 1'b0);
    step("rebr2", Idle, Fl, FLUSH, 1'b0);
    step("rebr3", Idle, AllOn, RUN, 1'b0);

    step("mw0", InMw, AllOff, RUN, 1'b0);
    step("mw1", InMwBr, AllOff, MEM_WAIT, 1'b0);
    step("mw2", InMw, AllOff, MEM_WAIT, 1'b0);
    step("mw3", InMr, AllOn, MEM_WAIT, 1'b0);
    step("mw4", Idle, AllOn, RUN, 1'b0);

    step("fmw0", InBr, Br, RUN, 1'b0);
    step("fmw1", InMw, AllOff, FLUSH, 1'b0);
    step("fmw2", InMr, AllOn, MEM_WAIT, 1'b0);
    step("fmw3", Idle, Fl, FLUSH, 1'b0);
    step("fmw4", Idle, AllOn, RUN, 1'b0);

    step("hlt0", InHlt, AllOn, RUN, 1'b0);
    for (int i = 0; i < 9; i++) step("hltw", Idle, AllOff, HALT, 1'b0);
    step("hltres", InRes, AllOff, HALT, 1'b0);
    step("hltrun", Idle, AllOn, RUN, 1'b0);

    step("to0", InMw, AllOff, RUN, 1'b0);
    step("to1", InMw, AllOff, MEM_WAIT, 1'b0);
    step("to2", InMw, AllOff, MEM_WAIT, 1'b0);
    step("to3", InMw, AllOff, MEM_WAIT, 1'b0);
    step("to4", Idle, AllOff, HALT, 1'b1);
    step("to5", InRes, AllOff, HALT, 1'b1);
    step("to6", Idle, AllOff, HALT, 1'b1);

    chk("sat.count", 32'(s_count), 32'd3);

    #2 rst_n = 1'b0;
    #1;
    chk("arst.state", 32'(state), 32'(RUN));
    chk("arst.timeout", 32'(timeout), 32'd0);
    chk("arst.count", stall_count, 32'd0);
    chk("arst.ctl", 32'(ctl_obs()), 32'(AllOn));
    chk("arst.sat", 32'(s_count), 32'd0);
    exp_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post0", Idle, AllOn, RUN, 1'b0);
    step("post1", InLu, LdUse, RUN, 1'b0);
    step("post2", Idle, AllOn, RUN, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush sequencer for the 5-stage pipeline (FETCH, DECODE, EXE, MEM, WB). Merges the load-use stall request from the hazard detector, taken-branch redirects from EXE, data-memory wait handshakes and halt/resume. It drives per-stage register enables and flush (bubble) signals, and keeps a saturating stall-cycle counter. It sits beside the pipeline registers; every stage register takes its enable and flush only from this block.

Parameters:
FLUSH_CYCLES, 2, number of cycles FETCH/DECODE flush is held after a taken branch (1..7)
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before a timeout fault (2..255)
CNT_WIDTH, 32, width of the stall-cycle counter

Ports:
clk_i  input  1  pipeline clock
rst_n_i  input  1  asynchronous active-low reset
load_use_stall_i  input  stall_pipeline_sig  load-use stall request from hazard detector
branch_taken_EXE_i  input  1  branch in EXE resolved taken (single-cycle pulse)
mem_req_MEM_i  input  1  instruction in MEM performs a data-memory access
mem_ready_i  input  1  data memory has completed the access this cycle
halt_WB_i  input  1  halt instruction retiring in WB
resume_i  input  1  leave HALT (pulse)
pc_en_o  output  1  PC register load enable
fetch_en_o, decode_en_o, exe_en_o, mem_en_o, wb_en_o  output  1 each  stage register enables
flush_decode_o, flush_exe_o  output  1 each  load a bubble (invalid) into that stage register
state_o  output  seq_state_t  current FSM state
mem_timeout_o  output  1  sticky fault: memory did not respond within MEM_TIMEOUT
stall_count_o  output  CNT_WIDTH  cycles with any enable low, saturating

Behaviour:
- Reset (rst_n_i low, asynchronous): state RUN, all enables 1, all flushes 0, mem_timeout_o 0, stall_count_o 0, internal counters 0.
- FSM states: RUN, MEM_WAIT, FLUSH, HALT. All outputs are combinational from state plus current inputs. Transitions take effect at the next rising edge.
- Priority within RUN: memory wait > branch > load-use.
- RUN, mem_req_MEM_i=1 and mem_ready_i=0: all enables 0 this cycle. Next state MEM_WAIT, wait counter loaded with 1.
- MEM_WAIT: all enables 0 and no flushes. Wait counter increments each cycle.
  - mem_ready_i=1: enables restored to 1 in that same cycle, next state RUN.
  - Counter reaches MEM_TIMEOUT with mem_ready_i still 0: mem_timeout_o set (sticky until reset), next state HALT.
  - Branch and load-use requests arriving during MEM_WAIT are ignored; the pipeline is frozen and they are re-presented.
- RUN, branch_taken_EXE_i=1 (memory not waiting): pc_en_o 1 (loads target), flush_decode_o 1, flush_exe_o 1, other enables 1.
  - If FLUSH_CYCLES>1: next state FLUSH, flush counter loaded with FLUSH_CYCLES-1.
  - Load-use in the same cycle is discarded; the flush wins.
- FLUSH: flush_decode_o 1 and pc_en_o 1 each cycle, counter decrements.
  - Counter reaches 1: next state RUN.
  - A new branch_taken_EXE_i in FLUSH reloads the counter to FLUSH_CYCLES-1.
  - mem_req_MEM_i with mem_ready_i=0 in FLUSH: MEM_WAIT has priority. The remaining flush count is kept and resumes after the wait.
- RUN, load_use_stall_i==STALL_PIPELINE (no branch, no memory wait): pc_en_o 0, fetch_en_o 0, decode_en_o 0, flush_exe_o 1, exe/mem/wb enables 1. Exactly one bubble per asserted cycle. State stays RUN.
- halt_WB_i=1 in RUN or FLUSH: WB completes this cycle, next state HALT.
- HALT: all enables 0, no flushes. resume_i=1 returns to RUN. resume_i has no effect while mem_timeout_o=1.
- stall_count_o increments every cycle in which any enable is 0, and holds at all-ones.
- Reset mid-operation returns to RUN immediately. No partial flush survives the reset.

Decomposition:
- Shared package (GENERAL_DEFS): seq_state_t enum {RUN, MEM_WAIT, FLUSH, HALT}. Reuse the existing stall_pipeline_sig / STALL_PIPELINE definitions.
- Sub-module sat_counter (parameterised width, inc, clear) for stall_count_o. It is reusable for other performance counters.

Test Plan:
- Release reset, idle inputs for 5 cycles -> state RUN, all enables 1, stall_count_o 0.
- load_use_stall_i=STALL_PIPELINE for 1 cycle -> pc/fetch/decode enables 0, flush_exe_o 1 for exactly 1 cycle, stall_count_o=1.
- FLUSH_CYCLES=2, branch_taken_EXE_i pulse -> flush_decode_o and flush_exe_o high in cycle 0, flush_decode_o high in cycle 1, state RUN in cycle 2. With load-use in cycle 0 there is no PC freeze.
- mem_req_MEM_i=1, mem_ready_i low for 3 cycles, then high -> all enables 0 for 3 cycles, restored on the ready cycle, stall_count_o=3.
- MEM_TIMEOUT=4, mem_ready_i never asserted -> mem_timeout_o=1 after 4 wait cycles, state HALT. resume_i pulse keeps HALT. Reset clears both.
- halt_WB_i pulse, then resume_i after 10 cycles -> HALT for 10 cycles with all enables 0, then RUN, stall_count_o=10.
